mean_rr_arbiter: RTL and testbench

//  Shares one pipelined mean unit (C = mean of A,B) between NREQ requesters.

---
 rtl/mean_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_mean_rr_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mean_rr_arbiter.sv
// Round-robin front end that shares one pipelined mean unit among NREQ requesters.
// Define MEAN_ARB_STATS_EN to add per-requester 16-bit saturating grant counters (grant_cnt).
module mean_rr_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned W         = 16,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_sign,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              m_enable,
    output logic              m_sign,
    output logic [W-1:0]      m_a,
    output logic [W-1:0]      m_b,
    output logic              m_ivalid,
    input  logic [W-1:0]      m_c,
    input  logic              m_ovalid,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [W-1:0]      rsp_data,
    output logic              err_orphan
`ifdef MEAN_ARB_STATS_EN
    ,
    output logic [NREQ*16-1:0] grant_cnt
`endif
);
    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CW = $clog2(TAG_DEPTH + 1);

    logic [IW-1:0] ptr;
    logic [IW-1:0] grant_idx;
    logic          grant_found;
    logic          can_grant;
    logic          handshake;
    logic          pop;
    logic [IW-1:0] tag_mem [TAG_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [IW-1:0] head_tag;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;
    logic          sel_sign;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(TAG_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign m_enable  = enable;
    // A pop in the same cycle does not free a slot for this cycle's grant.
    assign can_grant = enable && (count < CW'(TAG_DEPTH));
    assign pop       = m_ovalid && (count != '0);
    assign head_tag  = tag_mem[rd_ptr];

    // Round-robin search starting at ptr.
    always_comb begin
        int unsigned idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!grant_found && req_valid[IW'(idx)]) begin
                grant_found = 1'b1;
                grant_idx   = IW'(idx);
            end
        end
    end

    assign handshake = grant_found && can_grant;
    assign req_ready = handshake ? (NREQ'(1) << grant_idx) : '0;
    assign sel_a     = req_a[32'(grant_idx) * W +: W];
    assign sel_b     = req_b[32'(grant_idx) * W +: W];
    assign sel_sign  = req_sign[grant_idx];

    always_ff @(posedge clock) begin
        if (handshake) begin
            tag_mem[wr_ptr] <= grant_idx;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr        <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            m_a        <= '0;
            m_b        <= '0;
            m_sign     <= 1'b0;
            m_ivalid   <= 1'b0;
            rsp_valid  <= '0;
            rsp_data   <= '0;
            err_orphan <= 1'b0;
        end else begin
            m_ivalid <= handshake;
            if (handshake) begin
                m_a    <= sel_a;
                m_b    <= sel_b;
                m_sign <= sel_sign;
                ptr    <= (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + IW'(1);
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr   <= ptr_inc(rd_ptr);
                rsp_data <= m_c;
            end
            if (handshake && !pop) begin
                count <= count + CW'(1);
            end else if (!handshake && pop) begin
                count <= count - CW'(1);
            end
            rsp_valid <= pop ? (NREQ'(1) << head_tag) : '0;
            if (m_ovalid && (count == '0)) begin
                err_orphan <= 1'b1;
            end
        end
    end

`ifdef MEAN_ARB_STATS_EN
    // Per-requester grant counters, saturating at 16'hFFFF.
    always_ff @(posedge clock) begin
        if (reset) begin
            grant_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (handshake && (grant_idx == IW'(i)) && (grant_cnt[i*16 +: 16] != 16'hFFFF)) begin
                    grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_mean_rr_arbiter.sv
// Directed bench for mean_rr_arbiter: instance A (TAG_DEPTH=4, mean latency 2),
// instance B (TAG_DEPTH=2, mean latency 4); mean unit modelled as (A+B)>>>1.
`timescale 1ns/1ps
module tb_mean_rr_arbiter;
    localparam int unsigned NREQ = 4;
    localparam int unsigned W    = 16;
    localparam int          LA   = 2;
    localparam int          LB   = 4;

    typedef struct {
        logic       en;
        logic [3:0] valid;
        logic [3:0] exp_ready;
    } vec_t;

    typedef struct {
        logic [3:0]  oh;
        logic [15:0] data;
        int          due;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        en;
    logic        sel;
    logic [3:0]  valid;
    logic [3:0]  sign_v;
    logic [15:0] opa [4];
    logic [15:0] opb [4];
    logic [15:0] exp_mean [4];
    logic [63:0] a_v;
    logic [63:0] b_v;
    logic        inj_ov;
    logic [15:0] inj_c;

    assign a_v = {opa[3], opa[2], opa[1], opa[0]};
    assign b_v = {opb[3], opb[2], opb[1], opb[0]};

    logic [3:0]  valid_a, ready_a, rsp_valid_a;
    logic [3:0]  valid_b, ready_b, rsp_valid_b;
    logic        m_enable_a, m_sign_a, m_ivalid_a, m_ovalid_a, err_a;
    logic        m_enable_b, m_sign_b, m_ivalid_b, m_ovalid_b, err_b;
    logic [15:0] m_a_a, m_b_a, m_c_a, rsp_data_a;
    logic [15:0] m_a_b, m_b_b, m_c_b, rsp_data_b;
`ifdef MEAN_ARB_STATS_EN
    logic [63:0] grant_cnt_a, grant_cnt_b;
`endif

    assign valid_a = sel ? 4'b0000 : valid;
    assign valid_b = sel ? valid : 4'b0000;

    mean_rr_arbiter #(.NREQ(NREQ), .W(W), .TAG_DEPTH(4)) u_a (
        .clock(clk), .reset(reset), .enable(en),
        .req_valid(valid_a), .req_ready(ready_a), .req_sign(sign_v),
        .req_a(a_v), .req_b(b_v),
        .m_enable(m_enable_a), .m_sign(m_sign_a), .m_a(m_a_a), .m_b(m_b_a),
        .m_ivalid(m_ivalid_a), .m_c(m_c_a), .m_ovalid(m_ovalid_a),
        .rsp_valid(rsp_valid_a), .rsp_data(rsp_data_a), .err_orphan(err_a)
`ifdef MEAN_ARB_STATS_EN
        , .grant_cnt(grant_cnt_a)
`endif
    );

    mean_rr_arbiter #(.NREQ(NREQ), .W(W), .TAG_DEPTH(2)) u_b (
        .clock(clk), .reset(reset), .enable(en),
        .req_valid(valid_b), .req_ready(ready_b), .req_sign(sign_v),
        .req_a(a_v), .req_b(b_v),
        .m_enable(m_enable_b), .m_sign(m_sign_b), .m_a(m_a_b), .m_b(m_b_b),
        .m_ivalid(m_ivalid_b), .m_c(m_c_b), .m_ovalid(m_ovalid_b),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .err_orphan(err_b)
`ifdef MEAN_ARB_STATS_EN
        , .grant_cnt(grant_cnt_b)
`endif
    );

    function automatic logic [15:0] mean_fn(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        s = {a[15], a} + {b[15], b};
        return s[16:1];
    endfunction

    // Mean unit models
    logic [LA-1:0] pv_a;
    logic [15:0]   pd_a [LA];
    logic [LB-1:0] pv_b;
    logic [15:0]   pd_b [LB];

    always_ff @(posedge clk) begin
        if (reset) begin
            pv_a <= '0;
            pv_b <= '0;
        end else begin
            pv_a <= {pv_a[LA-2:0], m_ivalid_a};
            pv_b <= {pv_b[LB-2:0], m_ivalid_b};
        end
        pd_a[0] <= mean_fn(m_a_a, m_b_a);
        pd_b[0] <= mean_fn(m_a_b, m_b_b);
        for (int i = 1; i < LA; i++) pd_a[i] <= pd_a[i-1];
        for (int i = 1; i < LB; i++) pd_b[i] <= pd_b[i-1];
    end

    assign m_ovalid_a = pv_a[LA-1] | inj_ov;
    assign m_c_a      = inj_ov ? inj_c : pd_a[LA-1];
    assign m_ovalid_b = pv_b[LB-1];
    assign m_c_b      = pd_b[LB-1];

    // Observation of the selected instance
    logic [3:0]  ready_s, rsp_valid_s;
    logic        m_enable_s, m_sign_s, m_ivalid_s;
    logic [15:0] m_a_s, m_b_s, rsp_data_s;
    assign ready_s     = sel ? ready_b     : ready_a;
    assign rsp_valid_s = sel ? rsp_valid_b : rsp_valid_a;
    assign m_enable_s  = sel ? m_enable_b  : m_enable_a;
    assign m_sign_s    = sel ? m_sign_b    : m_sign_a;
    assign m_ivalid_s  = sel ? m_ivalid_b  : m_ivalid_a;
    assign m_a_s       = sel ? m_a_b       : m_a_a;
    assign m_b_s       = sel ? m_b_b       : m_b_a;
    assign rsp_data_s  = sel ? rsp_data_b  : rsp_data_a;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    rsp_t exp_q[$];
    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic mon_rsp();
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("rsp_valid", 32'(rsp_valid_s), 32'(exp_q[0].oh));
            check("rsp_data", 32'(rsp_data_s), 32'(exp_q[0].data));
            void'(exp_q.pop_front());
        end else begin
            check("rsp_idle", 32'(rsp_valid_s), 32'd0);
        end
    endtask

    task automatic tick(input logic e, input logic [3:0] v, input logic [3:0] exp_rdy);
        int gi;
        en    = e;
        valid = v;
        #1;
        check("req_ready", 32'(ready_s), 32'(exp_rdy));
        check("m_enable", 32'(m_enable_s), 32'(e));
        gi = -1;
        for (int i = 0; i < 4; i++) if (exp_rdy[i]) gi = i;
        if (gi >= 0) exp_q.push_back('{exp_rdy, exp_mean[gi], cyc + 2 + (sel ? LB : LA)});
        @(posedge clk);
        cyc++;
        #1;
        check("m_ivalid", 32'(m_ivalid_s), (gi >= 0) ? 32'd1 : 32'd0);
        if (gi >= 0) begin
            check("m_a", 32'(m_a_s), 32'(opa[gi]));
            check("m_b", 32'(m_b_s), 32'(opb[gi]));
            check("m_sign", 32'(m_sign_s), 32'(sign_v[gi]));
        end
        mon_rsp();
    endtask

    task automatic run_tbl();
        for (int i = 0; i < tbl.size(); i++) tick(tbl[i].en, tbl[i].valid, tbl[i].exp_ready);
        tbl.delete();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tbl.push_back('{1'b1, 4'b0000, 4'b0000});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        opa[0] = -16'sd31; opb[0] = 16'sd11; exp_mean[0] = -16'sd10;
        opa[1] = 16'sd100; opb[1] = -16'sd3; exp_mean[1] = 16'sd48;
        opa[2] = 16'sd11;  opb[2] = 16'sd21; exp_mean[2] = 16'sd16;
        opa[3] = -16'sd7;  opb[3] = -16'sd8; exp_mean[3] = -16'sd8;
        sign_v = 4'b1010;
        reset = 1'b1; en = 1'b0; sel = 1'b0; valid = 4'b0000;
        inj_ov = 1'b0; inj_c = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_ivalid", 32'(m_ivalid_a), 32'd0);
        check("rst_m_a", 32'(m_a_a), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst_err", 32'(err_a), 32'd0);
        check("rst_b_rsp_data", 32'(rsp_data_b), 32'd0);
        reset = 1'b0;

        // Single requests, then all-valid rotation, enable gating, wrap-around priority
        tbl.push_back('{1'b1, 4'b0001, 4'b0001}); idle(3);
        tbl.push_back('{1'b1, 4'b0100, 4'b0100}); idle(3);
        tbl.push_back('{1'b1, 4'b1000, 4'b1000}); idle(3);
        tbl.push_back('{1'b1, 4'b1111, 4'b0001});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000});
        tbl.push_back('{1'b1, 4'b1111, 4'b0001});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010}); idle(3);
        tbl.push_back('{1'b1, 4'b1111, 4'b0100});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000});
        tbl.push_back('{1'b0, 4'b1111, 4'b0000});
        tbl.push_back('{1'b1, 4'b1111, 4'b1000});
        tbl.push_back('{1'b1, 4'b0101, 4'b0001});
        tbl.push_back('{1'b1, 4'b0101, 4'b0100});
        tbl.push_back('{1'b1, 4'b0011, 4'b0001}); idle(3);
        run_tbl();
        check("queue_drained_a", 32'(exp_q.size()), 32'd0);

        // Orphan result with empty FIFO, then reset clears everything
        en = 1'b1; valid = 4'b0000; inj_ov = 1'b1; inj_c = 16'h1234;
        @(posedge clk); cyc++; #1;
        inj_ov = 1'b0;
        check("orphan_err", 32'(err_a), 32'd1);
        check("orphan_rsp", 32'(rsp_valid_a), 32'd0);
        @(posedge clk); cyc++; #1;
        check("orphan_sticky", 32'(err_a), 32'd1);
        reset = 1'b1;
        @(posedge clk); cyc++; #1;
        reset = 1'b0;
        check("rst2_err", 32'(err_a), 32'd0);
        check("rst2_m_a", 32'(m_a_a), 32'd0);
        check("rst2_m_b", 32'(m_b_a), 32'd0);
        check("rst2_m_sign", 32'(m_sign_a), 32'd0);
        check("rst2_m_ivalid", 32'(m_ivalid_a), 32'd0);
        check("rst2_rsp_valid", 32'(rsp_valid_a), 32'd0);
        check("rst2_rsp_data", 32'(rsp_data_a), 32'd0);
        tbl.push_back('{1'b1, 4'b1111, 4'b0001}); idle(3);
        run_tbl();

        // Tag FIFO full on the shallow instance: grants resume one cycle after the first pop
        sel = 1'b1;
        tbl.push_back('{1'b1, 4'b1111, 4'b0001});
        tbl.push_back('{1'b1, 4'b1111, 4'b0010});
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b1, 4'b1111, 4'b0000});
        tbl.push_back('{1'b1, 4'b1111, 4'b0100});
        idle(6);
        run_tbl();
        check("queue_drained_b", 32'(exp_q.size()), 32'd0);
        sel = 1'b0;

`ifdef MEAN_ARB_STATS_EN
        reset = 1'b1;
        @(posedge clk); cyc++; #1;
        reset = 1'b0;
        check("cnt_reset", grant_cnt_a[31:0], 32'd0);
        en = 1'b1; valid = 4'b0010;
        repeat (70000) @(posedge clk);
        #1;
        valid = 4'b0000;
        check("cnt_sat_req1", 32'(grant_cnt_a[31:16]), 32'h0000FFFF);
        check("cnt_req0", 32'(grant_cnt_a[15:0]), 32'd0);
        check("cnt_req23", grant_cnt_a[63:32], 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
